jk_cmd_sequencer: RTL
=====================

// Module: jk_cmd_sequencer
// PURPOSE
//   Upstream driver stage for the jkff flip-flop.
//   Accepts {op, count} commands over a valid/ready handshake and buffers them in a small FIFO.
//   Each command drives the flop's j/k inputs for count+1 clock cycles.
//   j/k are registered. Between commands they return to HOLD (j=0, k=0).
//   A done pulse marks the retirement of each command.
// PARAMETERS
//   DEPTH  4  FIFO entries; power of 2, >=2
//   CNT_W  4  width of cmd_cnt; one command drives up to 2**CNT_W cycles
// PORTS
//   clk        in   1            single clock; all state updates on posedge
//   rst        in   1            reset: asynchronous, active-low (0 = reset)
//   abort      in   1            sync clear: flush FIFO, drop active command
//   cmd_valid  in   1            command offered
//   cmd_ready  out  1            command accepted when cmd_valid && cmd_ready
//   cmd_op     in   2            00 HOLD, 01 RESET, 10 SET, 11 TOGGLE; {j,k} = cmd_op
//   cmd_cnt    in   CNT_W        drive cycles minus one
//   j          out  1            to jkff.j, registered
//   k          out  1            to jkff.k, registered
//   busy       out  1            1 while in DRIVE
//   done       out  1            1-cycle pulse on the last drive cycle of a command
//   level      out  clog2(D)+1   FIFO occupancy, 0..DEPTH
// BEHAVIOUR
//   Reset (rst=0, async)
//     - FIFO empty, level=0, state IDLE, counter=0.
//     - j=0, k=0, busy=0, done=0, cmd_ready=0.
//     - cmd_ready rises on the first posedge after rst deasserts.
//   Handshake
//     - cmd_ready = !full && !abort && out of reset.
//     - Push on valid&&ready.
//     - Full FIFO: no push, even if a pop occurs in the same cycle.
//     - Push and pop in the same cycle: level unchanged.
//   FSM states: IDLE, DRIVE
//     - IDLE, FIFO empty: j=k=0.
//     - IDLE, FIFO non-empty: pop; at the next edge {j,k}<=op, ctr<=cnt, busy<=1, go DRIVE.
//     - DRIVE, ctr!=0: ctr<=ctr-1; j/k held.
//     - DRIVE, ctr==0: done=1 this cycle.
//         - FIFO non-empty: pop and load the next command at that edge (no bubble).
//         - FIFO empty: j<=0, k<=0, busy<=0, go IDLE.
//   Latency
//     - Command pushed at edge N into an empty FIFO while IDLE: j/k take the value after edge N+1.
//     - j/k hold for exactly cnt+1 cycles.
//     - The jkff samples them at edges N+2 .. N+cnt+2.
//   Boundary conditions
//     - cnt=0: one drive cycle; done is asserted during that cycle.
//     - cnt=all-ones: 2**CNT_W cycles; ctr does not wrap.
//     - FIFO pointers wrap modulo DEPTH; level distinguishes full from empty.
//     - abort=1 (sync, priority over everything except rst):
//         - FIFO flushed, level<=0, state<=IDLE, j<=0, k<=0, busy<=0.
//         - No done pulse; any push in that cycle is dropped.
//     - rst asserted mid-DRIVE: immediate return to reset values; the command is lost.
//     - cmd_op/cmd_cnt are ignored when cmd_valid=0.
// TESTING
//   T1: rst=0 for 2 cycles, release -> j=k=0, busy=0, level=0; cmd_ready=1 one edge later.
//   T2: push {SET,cnt=2}
//       -> j=1, k=0 for 3 cycles; done on the 3rd; then j=k=0;
//       -> jkff q=1 after the first sampling edge.
//   T3: push {TOGGLE,3}, {RESET,0}, {HOLD,1} back-to-back
//       -> j/k sequence 11,11,11,11,01,00,00 with no gap;
//       -> done pulses at cycles 4, 5, 7; q toggles 4 times, then 0.
//   T4: push 5 commands with DEPTH=4 while the first drives
//       -> cmd_ready=0 at level=4; the 5th is held until a pop frees a slot.
//   T5: abort in the 2nd cycle of {SET,7} with 2 commands queued
//       -> next cycle j=k=0, busy=0, level=0, no done pulse.
//   T6: rst pulsed low mid-DRIVE of {TOGGLE,5} -> j/k go to 0 asynchronously, level=0.

Source files
------------

// File: rtl/jk_cmd_if.sv
// Command channel into jk_cmd_sequencer: {op, count} offered over valid/ready.
interface jk_cmd_if #(
    parameter int CNT_W = 4
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [CNT_W-1:0] cmd_cnt;

    modport master (output cmd_valid, output cmd_op, output cmd_cnt, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_op, input cmd_cnt, output cmd_ready);
endinterface

// File: rtl/jk_cmd_sequencer.sv
// Upstream driver for a JK flip-flop. Commands {op, cnt} are buffered in a
// small FIFO; each one drives {j,k} = op for cnt+1 cycles, back to back when
// the FIFO holds more work, and returns j/k to HOLD (00) when it runs dry.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   ST_IDLE  | no command active, j=k=0; pops the FIFO head if present
//   ST_DRIVE | j/k held at the active op while ctr counts down to zero
module jk_cmd_sequencer #(
    parameter  int DEPTH = 4,
    parameter  int CNT_W = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             abort,
    jk_cmd_if.slave          cmd,
    output logic             j,
    output logic             k,
    output logic             busy,
    output logic             done,
    output logic [LVL_W-1:0] level
);

    typedef enum logic {ST_IDLE, ST_DRIVE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   ctr_q, ctr_d;
    logic               j_q, j_d;
    logic               k_q, k_d;
    logic               busy_q, busy_d;
    logic               rdy_en_q, rdy_en_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic [CNT_W+1:0]   mem_q [DEPTH];

    logic               full;
    logic               empty;
    logic               last;
    logic               push;
    logic               pop;
    logic [CNT_W+1:0]   head;

    // Handshake, pop decision and next-state for the FSM and FIFO pointers.
    always_comb begin
        full          = (level_q == LVL_W'(DEPTH));
        empty         = (level_q == '0);
        last          = (state_q == ST_DRIVE) && (ctr_q == '0);
        cmd.cmd_ready = rdy_en_q && !full && !abort;
        push          = cmd.cmd_valid && cmd.cmd_ready;
        pop           = !abort && !empty && ((state_q == ST_IDLE) || last);
        done          = last && !abort;
        head          = mem_q[rd_ptr_q];

        state_d  = state_q;
        ctr_d    = ctr_q;
        j_d      = j_q;
        k_d      = k_q;
        busy_d   = busy_q;
        rdy_en_d = 1'b1;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;

        if (abort) begin
            // Flush everything; the active command is dropped without a done.
            state_d  = ST_IDLE;
            ctr_d    = '0;
            j_d      = 1'b0;
            k_d      = 1'b0;
            busy_d   = 1'b0;
            rd_ptr_d = wr_ptr_q;
            level_d  = '0;
        end else begin
            if (pop) begin
                // Load the head directly so consecutive commands have no bubble.
                state_d  = ST_DRIVE;
                {j_d, k_d} = head[CNT_W+1:CNT_W];
                ctr_d    = head[CNT_W-1:0];
                busy_d   = 1'b1;
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end else if (last) begin
                state_d  = ST_IDLE;
                j_d      = 1'b0;
                k_d      = 1'b0;
                busy_d   = 1'b0;
            end else if (state_q == ST_DRIVE) begin
                ctr_d    = ctr_q - CNT_W'(1);
            end

            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end

            case ({push, pop})
                2'b10:   level_d = level_q + LVL_W'(1);
                2'b01:   level_d = level_q - LVL_W'(1);
                default: level_d = level_q;
            endcase
        end
    end

    // Control state, outputs and FIFO bookkeeping; cleared asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            ctr_q    <= '0;
            j_q      <= 1'b0;
            k_q      <= 1'b0;
            busy_q   <= 1'b0;
            rdy_en_q <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            state_q  <= state_d;
            ctr_q    <= ctr_d;
            j_q      <= j_d;
            k_q      <= k_d;
            busy_q   <= busy_d;
            rdy_en_q <= rdy_en_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // FIFO storage; contents are don't-care while the level says empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {cmd.cmd_op, cmd.cmd_cnt};
        end
    end

    assign j     = j_q;
    assign k     = k_q;
    assign busy  = busy_q;
    assign level = level_q;

endmodule
